inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/inst_fetch_hold_buf.sv | 32 +++
 rtl/inst_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch constants: word sizes, NOP encoding and fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int unsigned INST_W     = 32;
  localparam logic [31:0] INST_BYTES = 32'd4;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_hold_buf.sv
// Single-entry skid buffer holding one stalled instruction and its pc.
module fetch_hold_buf
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] load_inst,
  input  logic [31:0]       load_pc,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       pc,
  output logic              valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst  <= INST_NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      inst  <= INST_NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= load_inst;
      pc    <= load_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage for a 1-cycle-latency instruction BRAM with stall/redirect.
// Optional macro INST_FETCH_PERF_EN adds fetch_count / bubble_count counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]      imem_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [INST_W-1:0]      inst,
  output logic [31:0]            pc
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            bubble_count
`endif
);

  fetch_state_t state, next_state;
  // fetch_pc: address issued last cycle (RUN) or the pending re-issued address (HOLD)
  logic [31:0]       fetch_pc, fetch_pc_next, issue_pc;
  logic              hold_load, hold_clear, hold_valid;
  logic [INST_W-1:0] hold_inst, sel_inst;
  logic [31:0]       hold_pc;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_inst (imem_data),
    .load_pc   (fetch_pc),
    .inst      (hold_inst),
    .pc        (hold_pc),
    .valid     (hold_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= fetch_pc_next;
    end
  end

  always_comb begin
    next_state    = state;
    issue_pc      = fetch_pc;
    fetch_pc_next = fetch_pc;
    inst_valid    = 1'b0;
    sel_inst      = INST_NOP;
    pc            = fetch_pc;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;
    case (state)
      ST_BOOT: begin
        issue_pc      = RESET_PC;
        fetch_pc_next = RESET_PC;
        next_state    = ST_RUN;
      end
      ST_RUN: begin
        inst_valid    = 1'b1;
        sel_inst      = imem_data;
        issue_pc      = fetch_pc + INST_BYTES;
        fetch_pc_next = issue_pc;
        if (stall) begin
          hold_load  = 1'b1;
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        inst_valid = hold_valid;
        sel_inst   = hold_inst;
        pc         = hold_pc;
        if (!stall) next_state = ST_RUN;
      end
      default: next_state = ST_BOOT;
    endcase
    // Redirect overrides everything outside BOOT, including a concurrent stall.
    if (state != ST_BOOT && redirect_valid) begin
      inst_valid    = 1'b0;
      issue_pc      = redirect_pc & ~32'd3;
      fetch_pc_next = issue_pc;
      hold_load     = 1'b0;
      hold_clear    = 1'b1;
      next_state    = ST_RUN;
    end
  end

  assign inst      = inst_valid ? sel_inst : INST_NOP;
  assign imem_en   = ~rst;
  assign imem_addr = IMEM_ADDR_W'(issue_pc >> 2);

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (inst_valid && !stall) fetch_count <= fetch_count + 32'd1;
      if (!inst_valid && state != ST_BOOT) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
